ebpf_shift_exec: RTL and testbench
==================================

# ebpf_shift_exec

Two-stage pipelined shift execute unit for the eBPF core ALU. It accepts decoded LSH/RSH/ARSH operations from the issue stage over a valid/ready handshake and applies eBPF shift-amount masking and ALU32 semantics. It drives the combinational 64-bit shifter and returns the registered result, with its destination register index, to writeback. Sustains one operation per cycle when writeback does not stall.

## Interface
- DST_W, default 4: destination register index width (r0..r10).
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill (branch redirect/exception).
- in_valid  in  1  issue stage offers an operation.
- in_ready  out  1  unit accepts the operation this cycle.
- in_op  in  2  0=LSH, 1=RSH (logical), 2=ARSH, 3=reserved.
- in_alu32  in  1  1 = 32-bit ALU class, 0 = ALU64.
- in_a  in  64  dst operand (value shifted).
- in_b  in  64  src/immediate operand (shift amount).
- in_dst  in  DST_W  destination register index.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes the result.
- out_result  out  64  shifted value.
- out_dst  out  DST_W  destination index, carried with the result.
- out_err  out  1  operation was reserved op 3 (illegal instruction).

## Operation
- Stage 1 (S1): captures op, alu32, dst, operand a, and masked shift amount on accept (in_valid && in_ready).
- Shift amount: ALU64 uses in_b[5:0]; ALU32 uses in_b[4:0]. Upper bits of in_b are ignored, never saturated.
- ALU32 operand: a[31:0] only. ARSH32 sign source is a[31]. Result bits [63:32] are forced to 0 for all ALU32 ops.
- ALU64: LSH = a<<sh, RSH = a>>sh zero-fill, ARSH = sign-fill from a[63].
- Stage 2 (S2): registers the result computed from S1 contents plus dst and err.
- Op 3: out_result = 0 and out_err = 1. Handshake behaves as a normal op.
- Handshake: S1 advances when !s2_valid || out_ready. in_ready = !s1_valid || s1_advance (combinational from out_ready; no bubble on full-throughput streaming).
- Data stability: out_result/out_dst/out_err are held stable while out_valid && !out_ready.
- flush: clears s1_valid and s2_valid at the next edge. An input offered in the flush cycle is dropped. in_ready may be high during flush.
- Simultaneous accept and drain: both stages update in the same cycle. No data loss or duplication.

## Timing
- Latency: operation accepted at edge N appears with out_valid=1 after edge N+1 (visible in cycle N+1, consumable at edge N+2 if out_ready).
- Throughput: 1 op/cycle with out_ready held high.
- Stall: when out_ready=0 with both stages full, in_ready=0 in the same cycle. When out_ready rises, in_ready rises combinationally.
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_dst=0, out_err=0. in_ready reads 1 while in reset and after.
- Reset mid-operation: all in-flight ops are discarded. No output is produced for them after reset release.
- flush has priority over accept and advance in the same cycle.

## Test plan
- ALU64 RSH a=0xF000_0000_0000_0001, b=0x44 (masked to 4) -> out_result=0x0F00_0000_0000_0000, out_err=0, out_valid exactly one cycle after accept.
- ARSH64 a=0x8000_0000_0000_0000, b=63 -> 0xFFFF_FFFF_FFFF_FFFF. ARSH32 a=0x1234_5678_8000_0000, b=0x21 (masked to 1) -> 0x0000_0000_C000_0000.
- LSH32 a=0x0000_0000_8000_0001, b=1 -> 0x0000_0000_0000_0002 (upper half zeroed). LSH64 same operands -> 0x0000_0001_0000_0002.
- Stream 8 back-to-back ops with out_ready=1 -> 8 results on consecutive cycles, dst order preserved. Then hold out_ready=0 for 3 cycles -> in_ready=0 after two ops are buffered, output held stable, no loss on release.
- Op 3 with dst=5 -> out_err=1, out_result=0, out_dst=5. flush with both stages full -> out_valid=0 next cycle, no flushed op appears.
- Assert rst_n low asynchronously mid-stream (between clock edges) -> out_valid drops immediately, all outputs 0. After release, the first new op completes with normal latency.

Source files
------------

// File: rtl/ebpf_shift_exec.sv
// ebpf_shift_exec: two-stage pipelined shift execute unit for the eBPF ALU.
//
// Handles LSH / RSH / ARSH in both ALU64 and ALU32 classes. Stage 1 captures
// the decoded operation with the shift amount already masked to the class
// width. Stage 2 registers the shifter output together with the destination
// index and the illegal-op flag. The unit streams one operation per cycle
// while writeback keeps out_ready high.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   flush              synchronous kill of both stages
//   in_valid/in_ready  issue handshake
//   in_op              0=LSH, 1=RSH, 2=ARSH, 3=reserved (flagged via out_err)
//   in_alu32           1 = ALU32 class, 0 = ALU64
//   in_a, in_b         value to shift, shift amount source
//   in_dst             destination register index
//   out_valid/ready    writeback handshake
//   out_result         shifted value
//   out_dst            destination index carried with the result
//   out_err            reserved opcode was executed
module ebpf_shift_exec #(
  parameter int DST_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_alu32,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [DST_W-1:0] in_dst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [DST_W-1:0] out_dst,
  output logic             out_err
);

  typedef enum logic [1:0] {
    OP_LSH  = 2'd0,
    OP_RSH  = 2'd1,
    OP_ARSH = 2'd2,
    OP_RSVD = 2'd3
  } shift_op_e;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  shift_op_e        s1_op_q,    s1_op_d;
  logic             s1_alu32_q, s1_alu32_d;
  logic [DST_W-1:0] s1_dst_q,   s1_dst_d;
  logic [63:0]      s1_a_q,     s1_a_d;
  logic [5:0]       s1_sh_q,    s1_sh_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [63:0]      s2_res_q,   s2_res_d;
  logic [DST_W-1:0] s2_dst_q,   s2_dst_d;
  logic             s2_err_q,   s2_err_d;

  logic        s1_advance;
  logic        accept;
  logic [63:0] shift_res;
  logic [31:0] a32;
  logic [4:0]  sh5;

  // S1 may move forward whenever S2 is empty or being drained this cycle,
  // so in_ready follows out_ready combinationally and streaming has no bubble.
  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign accept     = in_valid && in_ready && !flush;

  assign a32 = s1_a_q[31:0];
  assign sh5 = s1_sh_q[4:0];

  // Combinational shifter working on S1 contents.
  // NOTE: every signal driven in an always_comb gets a default on entry so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    shift_res = '0;
    if (s1_alu32_q) begin
      // ALU32: only a[31:0] participates and the upper half is always zero.
      case (s1_op_q)
        OP_LSH:  shift_res = {32'b0, a32 << sh5};
        OP_RSH:  shift_res = {32'b0, a32 >> sh5};
        OP_ARSH: shift_res = {32'b0, $unsigned($signed(a32) >>> sh5)};
        default: shift_res = '0;
      endcase
    end else begin
      case (s1_op_q)
        OP_LSH:  shift_res = s1_a_q << s1_sh_q;
        OP_RSH:  shift_res = s1_a_q >> s1_sh_q;
        OP_ARSH: shift_res = $unsigned($signed(s1_a_q) >>> s1_sh_q);
        default: shift_res = '0;
      endcase
    end
  end

  // Stage 1 next state. Flush wins over accept and advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_alu32_d = s1_alu32_q;
    s1_dst_d   = s1_dst_q;
    s1_a_d     = s1_a_q;
    s1_sh_d    = s1_sh_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = shift_op_e'(in_op);
      s1_alu32_d = in_alu32;
      s1_dst_d   = in_dst;
      s1_a_d     = in_a;
      // Shift amount is masked, never saturated: high bits of in_b are ignored.
      s1_sh_d    = in_alu32 ? {1'b0, in_b[4:0]} : in_b[5:0];
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state. Payload only changes when a valid op moves in, which
  // keeps the outputs stable while writeback stalls.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_dst_d   = s2_dst_q;
    s2_err_d   = s2_err_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s1_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d = shift_res;
        s2_dst_d = s1_dst_q;
        s2_err_d = (s1_op_q == OP_RSVD);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  // NOTE: the datapath registers are reset as well as the valids, because the
  // result outputs must read zero during and right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_LSH;
      s1_alu32_q <= 1'b0;
      s1_dst_q   <= '0;
      s1_a_q     <= '0;
      s1_sh_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_dst_q   <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_alu32_q <= s1_alu32_d;
      s1_dst_q   <= s1_dst_d;
      s1_a_q     <= s1_a_d;
      s1_sh_q    <= s1_sh_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_dst_q   <= s2_dst_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_res_q;
  assign out_dst    = s2_dst_q;
  assign out_err    = s2_err_q;

endmodule

// File: tb/tb_ebpf_shift_exec.sv
// tb_ebpf_shift_exec: directed scoreboard bench for ebpf_shift_exec.
// The driver pushes a hand-computed expected result whenever an op is
// accepted; a monitor on the falling edge pops and compares on every
// out_valid && out_ready transfer.
module tb_ebpf_shift_exec;

  localparam int DST_W = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_alu32;
  logic [63:0]      in_a;
  logic [63:0]      in_b;
  logic [DST_W-1:0] in_dst;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [DST_W-1:0] out_dst;
  logic             out_err;

  typedef struct packed {
    logic [63:0]      res;
    logic [DST_W-1:0] dst;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pop_cyc[$];
  int   total   = 0;
  int   bad     = 0;
  int   pop_cnt = 0;
  int   cyc     = 0;
  int   pc;

  ebpf_shift_exec #(.DST_W(DST_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_alu32   (in_alu32),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_dst     (in_dst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dst    (out_dst),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: consume one expected entry per output transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pop_cnt++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual dst=%0d result=%h required=none",
                 out_dst, out_result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", out_result, mon_e.res);
        check("dst", 64'(out_dst), 64'(mon_e.dst));
        check("err", 64'(out_err), 64'(mon_e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op and hold it until accepted (bounded). Returns 1 time unit
  // after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic a32,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [DST_W-1:0] dst, input logic [63:0] res);
    bit   done;
    exp_t e;
    done     = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_alu32 = a32;
    in_a     = a;
    in_b     = b;
    in_dst   = dst;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        e.res = res;
        e.dst = dst;
        e.err = (op == 2'd3);
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout dst=%0d in_ready=%b required=1", dst, in_ready);
    end
  endtask

  // Back-to-back stream table (dst = index).
  logic [1:0]  st_op  [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1};
  logic        st_32  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [63:0] st_a   [8] = '{64'h1, 64'h1, 64'h8000_0000_0000_0000,
                              64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
                              64'h0000_0000_8000_0000, 64'h1,
                              64'h1234_5678_9ABC_DEF0};
  logic [63:0] st_b   [8] = '{64'd0, 64'd63, 64'd63, 64'd62, 64'd31, 64'd31,
                              64'h3F, 64'h104};
  logic [63:0] st_exp [8] = '{64'h1, 64'h8000_0000_0000_0000, 64'h1, 64'h1,
                              64'h1, 64'h0000_0000_FFFF_FFFF,
                              64'h0000_0000_8000_0000, 64'h0123_4567_89AB_CDEF};

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_alu32  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_dst    = '0;
    out_ready = 1'b1;

    // Reset state
    #7;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_dst", 64'(out_dst), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // RSH64 with masked amount, plus latency check
    issue(2'd1, 1'b0, 64'hF000_0000_0000_0001, 64'h44, 4'd1, 64'h0F00_0000_0000_0000);
    check("lat_not_yet", 64'(out_valid), 64'd0);
    tick();
    check("lat_visible", 64'(out_valid), 64'd1);
    tick();

    issue(2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(2'd2, 1'b1, 64'h1234_5678_8000_0000, 64'h21, 4'd3, 64'h0000_0000_C000_0000);
    issue(2'd0, 1'b1, 64'h0000_0000_8000_0001, 64'd1, 4'd4, 64'h0000_0000_0000_0002);
    issue(2'd0, 1'b0, 64'h0000_0000_8000_0001, 64'd1, 4'd5, 64'h0000_0001_0000_0002);
    // ALU32 amount 0x20 masks to 0; upper half of a dropped
    issue(2'd1, 1'b1, 64'hFFFF_FFFF_1234_5678, 64'h20, 4'd6, 64'h0000_0000_1234_5678);
    repeat (3) tick();

    // Stream 8 ops back-to-back
    pop_cyc.delete();
    for (int i = 0; i < 8; i++)
      issue(st_op[i], st_32[i], st_a[i], st_b[i], 4'(i), st_exp[i]);
    repeat (3) tick();
    check("stream_count", 64'(pop_cyc.size()), 64'd8);
    for (int i = 1; i < 8 && i < pop_cyc.size(); i++)
      check("stream_consecutive", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

    // Stall: two ops buffered, third refused, output stable
    out_ready = 1'b0;
    issue(2'd0, 1'b0, 64'h10, 64'd4, 4'd8, 64'h100);
    issue(2'd1, 1'b0, 64'h100, 64'd8, 4'd9, 64'h1);
    in_valid = 1'b1;
    in_op    = 2'd2;
    in_alu32 = 1'b0;
    in_a     = 64'hFFFF_FFFF_FFFF_FF00;
    in_b     = 64'd4;
    in_dst   = 4'd10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_result", out_result, 64'h100);
      check("stall_dst", 64'(out_dst), 64'd8);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    issue(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FF00, 64'd4, 4'd10, 64'hFFFF_FFFF_FFFF_FFF0);
    repeat (3) tick();

    // Reserved op
    issue(2'd3, 1'b0, 64'hDEAD_BEEF, 64'd1, 4'd5, 64'h0);
    repeat (3) tick();

    // Flush with both stages full; inputs during flush are dropped
    out_ready = 1'b0;
    issue(2'd0, 1'b0, 64'h1, 64'd1, 4'd1, 64'h2);
    issue(2'd0, 1'b0, 64'h1, 64'd2, 4'd2, 64'h4);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 2'd0;
    in_a     = 64'h1;
    in_b     = 64'd3;
    in_dst   = 4'd3;
    tick();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    in_dst = 4'd4;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush2_out_valid", 64'(out_valid), 64'd0);
    check("flush_s1_empty", 64'(in_ready), 64'd1);
    exp_q.delete();
    out_ready = 1'b1;
    pc = pop_cnt;
    repeat (4) tick();
    check("flush_no_output", 64'(pop_cnt), 64'(pc));

    // Asynchronous reset mid-stream
    issue(2'd0, 1'b0, 64'h3, 64'd1, 4'd11, 64'h6);
    issue(2'd0, 1'b0, 64'h3, 64'd2, 4'd12, 64'hC);
    issue(2'd0, 1'b0, 64'h3, 64'd3, 4'd13, 64'h18);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_result", out_result, 64'd0);
    check("arst_out_dst", 64'(out_dst), 64'd0);
    check("arst_out_err", 64'(out_err), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    #8;
    rst_n = 1'b1;
    tick();
    pc = pop_cnt;
    repeat (3) tick();
    check("post_reset_no_output", 64'(pop_cnt), 64'(pc));
    issue(2'd1, 1'b0, 64'h80, 64'd7, 4'd7, 64'h1);
    check("post_reset_lat_not_yet", 64'(out_valid), 64'd0);
    tick();
    check("post_reset_lat_visible", 64'(out_valid), 64'd1);
    repeat (3) tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
